retire_commit_unit: RTL and testbench
=====================================

Name: retire_commit_unit

Overview:
- Parametrised commit stage. Sits behind COMPLETE and consumes the retired ROB rows.
- RegWrite rows: issues registered write-backs to the register file.
- MemWrite rows: reads the store value from the register file, pushes {addr, data} into an in-order store buffer, and drains it to memory write ports under a ready handshake.
- Replaces ad-hoc retire logic. Adds backpressure, arbitrary retire width and buffered stores.

Parameters:
- RETIRE_W, 2, ROB rows presented per cycle (lanes).
- MEM_PORTS, 2, memory write ports drained per cycle; 1..RETIRE_W.
- SB_DEPTH, 8, store buffer entries; power of two, at least RETIRE_W.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_retire_rows  in  rob_row_struct[0:RETIRE_W-1]  retiring rows; uses valid, RegWrite, MemWrite, PRegAddrDst, data.
- o_retire_ready  out  1  rows are accepted this cycle when high.
- o_reg_w_en  out  logic[0:RETIRE_W-1]  register write enable per lane.
- o_reg_w_addr  out  p_reg[0:RETIRE_W-1]  register write address.
- o_reg_w_data  out  word[0:RETIRE_W-1]  register write data.
- o_st_r_addr  out  p_reg[0:RETIRE_W-1]  combinational register read address for store value; equals lane PRegAddrDst.
- i_st_r_data  in  word[0:RETIRE_W-1]  same-cycle read data.
- i_mem_ready  in  1  memory accepts writes this cycle.
- o_mem_w_en  out  logic[0:MEM_PORTS-1]  memory write enable.
- o_mem_w_addr  out  word[0:MEM_PORTS-1]  memory write address.
- o_mem_w_data  out  word[0:MEM_PORTS-1]  memory write data.
- o_sb_empty  out  1  store buffer holds no entries.
- o_retired_cnt  out  32  total rows accepted since reset; wraps.
- o_stores_cnt  out  32  total stores written to memory since reset; wraps.

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - all enables 0, addr/data 0, counters 0;
  - store buffer emptied (head=tail=count=0);
  - o_sb_empty=1, o_retire_ready=1.
  - Reset mid-drain discards buffered stores.
- Accept: on posedge with o_retire_ready=1, each lane with valid=1 is accepted. Invalid lanes are ignored, and gaps between valid lanes are allowed.
- Lane classification:
  - MemWrite=1 is a store and takes priority over RegWrite;
  - else RegWrite=1 is a register write;
  - else the row is counted only.
- Register write latency is 1 cycle:
  - o_reg_w_en[i]=1 with addr=PRegAddrDst and data=row.data in the cycle after accept;
  - o_reg_w_en[i]=0 otherwise. Lane i maps to write port i.
- Store enqueue: in the accept cycle, entry {addr=row.data, data=i_st_r_data[i]} is written at the tail.
  - Multiple stores in one cycle are compacted in ascending lane order.
  - tail advances by the number of stores, modulo SB_DEPTH.
- o_retire_ready is combinational: high iff (SB_DEPTH - count) >= RETIRE_W. This is conservative and independent of the current lane contents. When low, rows are not accepted and o_retired_cnt does not change.
- Drain:
  - o_mem_w_en[k]=1 for k < min(count, MEM_PORTS), presenting the entry at (head+k) mod SB_DEPTH (combinational from buffer state).
  - A write is taken on posedge when i_mem_ready=1: head advances by the number of enabled ports and o_stores_cnt increases by the same amount.
  - When i_mem_ready=0, head and the outputs hold.
  - Ordering: memory sees stores strictly in retire order.
- Simultaneous enqueue and dequeue: count_next = count + enq - deq. A full buffer may drain and refill in the same cycle. A buffer with count=0 never presents writes; enqueued entries become visible the next cycle (no bypass).
- o_sb_empty = (count==0). It is used for fences and end-of-test.
- Widths:
  - pointers are $clog2(SB_DEPTH) bits and wrap naturally;
  - count is $clog2(SB_DEPTH+1) bits;
  - counters wrap at 2^32.

Decomposition:
- Add the following to package Types:
  - store_buffer_entry_struct {word addr; word data;};
  - localparams SB_PTR_W and SB_CNT_W derived in-module from SB_DEPTH.
- Natural sub-module: store_buffer — a multi-enqueue (RETIRE_W) / multi-dequeue (MEM_PORTS) circular FIFO with count, head/tail and a free-slot output.
- retire_commit_unit instantiates store_buffer and holds lane classification, register write-back registers and counters.

Test Plan:
- Reset, then lane0 {valid,RegWrite,PRegAddrDst=5,data=0x1234} → next cycle o_reg_w_en[0]=1, addr 5, data 0x1234; following cycle en=0; o_retired_cnt=1.
- Lane0 store data=0x40 with i_st_r_data[0]=0xAA and lane1 store data=0x44 with 0xBB, i_mem_ready=1 → next cycle o_mem_w_en={1,1} with (0x40,0xAA),(0x44,0xBB); then o_sb_empty=1 and o_stores_cnt=2.
- i_mem_ready=0; issue 3 cycles of 2 stores, then try 2 more rows (count=6, SB_DEPTH=8) → o_retire_ready=1 once more; count=8 → ready=0 and the 5th batch is held, not counted. Raise ready → drains 2/cycle in order, ready returns.
- Lane0 invalid, lane1 store addr 0x80 → single entry, presented on port 0 only.
- Row with both MemWrite=1 and RegWrite=1 → store enqueued, o_reg_w_en stays 0.
- 4 stores buffered, assert i_rst_n=0 for one cycle → all o_mem_w_en=0, o_sb_empty=1, counters 0, ready=1.

Source files
------------

// File: rtl/retire_commit_unit_pkg.sv
// Shared types for the retire/commit stage: ROB row payload and store buffer entry.
package retire_commit_unit_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PREG_W = 7;

  typedef logic [WORD_W-1:0] word;
  typedef logic [PREG_W-1:0] p_reg;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_write;
    p_reg p_reg_addr_dst;
    word  data;
  } rob_row_struct;

  typedef struct packed {
    word addr;
    word data;
  } store_buffer_entry_struct;

endpackage

// File: rtl/retire_commit_unit_store_buffer.sv
// In-order circular store FIFO: up to ENQ_W compacted pushes and DEQ_W pops per cycle.
module retire_commit_unit_store_buffer
  import retire_commit_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ENQ_W = 2,
  parameter int unsigned DEQ_W = 2,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     enq_en_i      [ENQ_W],
  input  store_buffer_entry_struct enq_entry_i   [ENQ_W],
  input  logic                     deq_ready_i,
  output logic                     deq_en_c_o    [DEQ_W],
  output store_buffer_entry_struct deq_entry_c_o [DEQ_W],
  output logic [CNT_W-1:0]         deq_num_c_o,
  output logic [CNT_W-1:0]         count_o,
  output logic [CNT_W-1:0]         free_c_o
);

  store_buffer_entry_struct mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] enq_num;
  logic [CNT_W-1:0] deq_avail;
  logic [PTR_W-1:0] wr_slot [ENQ_W];
  logic [PTR_W-1:0] rd_slot [DEQ_W];

  // Compact pushing lanes onto consecutive slots starting at the tail
  always_comb begin
    enq_num = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      wr_slot[i] = tail_q + PTR_W'(enq_num);
      if (enq_en_i[i]) enq_num = enq_num + CNT_W'(1);
    end
  end

  always_comb begin
    deq_avail   = (count_q < CNT_W'(DEQ_W)) ? count_q : CNT_W'(DEQ_W);
    deq_num_c_o = deq_ready_i ? deq_avail : '0;
    for (int k = 0; k < DEQ_W; k++) begin
      rd_slot[k]       = head_q + PTR_W'(k);
      deq_en_c_o[k]    = CNT_W'(k) < deq_avail;
      deq_entry_c_o[k] = deq_en_c_o[k] ? mem_q[rd_slot[k]] : '0;
    end
    head_d  = head_q + PTR_W'(deq_num_c_o);
    tail_d  = tail_q + PTR_W'(enq_num);
    count_d = count_q + enq_num - deq_num_c_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (rst_n_i && enq_en_i[i]) mem_q[wr_slot[i]] <= enq_entry_i[i];
    end
  end

  assign count_o  = count_q;
  assign free_c_o = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/retire_commit_unit.sv
// Commit stage: classifies retiring ROB rows into register write-backs and buffered stores.
module retire_commit_unit
  import retire_commit_unit_pkg::*;
#(
  parameter int unsigned RETIRE_W  = 2,
  parameter int unsigned MEM_PORTS = 2,
  parameter int unsigned SB_DEPTH  = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  rob_row_struct i_retire_rows [RETIRE_W],
  output logic          o_retire_ready,
  output logic          o_reg_w_en    [RETIRE_W],
  output p_reg          o_reg_w_addr  [RETIRE_W],
  output word           o_reg_w_data  [RETIRE_W],
  output p_reg          o_st_r_addr   [RETIRE_W],
  input  word           i_st_r_data   [RETIRE_W],
  input  logic          i_mem_ready,
  output logic          o_mem_w_en    [MEM_PORTS],
  output word           o_mem_w_addr  [MEM_PORTS],
  output word           o_mem_w_data  [MEM_PORTS],
  output logic          o_sb_empty,
  output logic [31:0]   o_retired_cnt,
  output logic [31:0]   o_stores_cnt
);

  localparam int unsigned SB_PTR_W   = $clog2(SB_DEPTH);
  localparam int unsigned SB_CNT_W   = $clog2(SB_DEPTH + 1);
  localparam int unsigned LANE_CNT_W = $clog2(RETIRE_W + 1);

  logic                     st_en     [RETIRE_W];
  store_buffer_entry_struct st_entry  [RETIRE_W];
  logic                     deq_en    [MEM_PORTS];
  store_buffer_entry_struct deq_entry [MEM_PORTS];
  logic [SB_CNT_W-1:0]      deq_num, sb_count, sb_free;
  logic [LANE_CNT_W-1:0]    acc_num;

  logic  reg_w_en_q   [RETIRE_W];
  logic  reg_w_en_d   [RETIRE_W];
  p_reg  reg_w_addr_q [RETIRE_W];
  p_reg  reg_w_addr_d [RETIRE_W];
  word   reg_w_data_q [RETIRE_W];
  word   reg_w_data_d [RETIRE_W];
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] stores_cnt_q, stores_cnt_d;

  // Ready only when a full batch of stores is guaranteed to fit
  assign o_retire_ready = sb_free >= SB_CNT_W'(RETIRE_W);
  assign o_sb_empty     = sb_count == '0;

  // Store wins over register write when both flags are set
  always_comb begin
    acc_num = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      o_st_r_addr[i]  = i_retire_rows[i].p_reg_addr_dst;
      st_en[i]        = o_retire_ready && i_retire_rows[i].valid && i_retire_rows[i].mem_write;
      st_entry[i]     = '{addr: i_retire_rows[i].data, data: i_st_r_data[i]};
      reg_w_en_d[i]   = o_retire_ready && i_retire_rows[i].valid &&
                        !i_retire_rows[i].mem_write && i_retire_rows[i].reg_write;
      reg_w_addr_d[i] = reg_w_en_d[i] ? i_retire_rows[i].p_reg_addr_dst : '0;
      reg_w_data_d[i] = reg_w_en_d[i] ? i_retire_rows[i].data : '0;
      if (o_retire_ready && i_retire_rows[i].valid) acc_num = acc_num + LANE_CNT_W'(1);
    end
    retired_cnt_d = retired_cnt_q + 32'(acc_num);
    stores_cnt_d  = stores_cnt_q + 32'(deq_num);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RETIRE_W; i++) begin
        reg_w_en_q[i]   <= 1'b0;
        reg_w_addr_q[i] <= '0;
        reg_w_data_q[i] <= '0;
      end
      retired_cnt_q <= '0;
      stores_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < RETIRE_W; i++) begin
        reg_w_en_q[i]   <= reg_w_en_d[i];
        reg_w_addr_q[i] <= reg_w_addr_d[i];
        reg_w_data_q[i] <= reg_w_data_d[i];
      end
      retired_cnt_q <= retired_cnt_d;
      stores_cnt_q  <= stores_cnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < MEM_PORTS; k++) begin
      o_mem_w_en[k]   = deq_en[k];
      o_mem_w_addr[k] = deq_entry[k].addr;
      o_mem_w_data[k] = deq_entry[k].data;
    end
  end

  assign o_reg_w_en    = reg_w_en_q;
  assign o_reg_w_addr  = reg_w_addr_q;
  assign o_reg_w_data  = reg_w_data_q;
  assign o_retired_cnt = retired_cnt_q;
  assign o_stores_cnt  = stores_cnt_q;

  retire_commit_unit_store_buffer #(
    .DEPTH (SB_DEPTH),
    .ENQ_W (RETIRE_W),
    .DEQ_W (MEM_PORTS),
    .PTR_W (SB_PTR_W),
    .CNT_W (SB_CNT_W)
  ) u_store_buffer (
    .clk_i         (i_clk),
    .rst_n_i       (i_rst_n),
    .enq_en_i      (st_en),
    .enq_entry_i   (st_entry),
    .deq_ready_i   (i_mem_ready),
    .deq_en_c_o    (deq_en),
    .deq_entry_c_o (deq_entry),
    .deq_num_c_o   (deq_num),
    .count_o       (sb_count),
    .free_c_o      (sb_free)
  );

endmodule

// File: tb/tb_retire_commit_unit.sv
// Scoreboard bench for retire_commit_unit against a queue-based reference model.
module tb_retire_commit_unit;
  import retire_commit_unit_pkg::*;

  localparam int unsigned RW = 2;
  localparam int unsigned MP = 2;
  localparam int unsigned SD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  rob_row_struct rows [RW];
  word           st_data [RW];
  logic          mem_ready = 1'b0;

  logic        retire_ready, sb_empty;
  logic        reg_w_en [RW];
  p_reg        reg_w_addr [RW];
  word         reg_w_data [RW];
  p_reg        st_r_addr [RW];
  logic        mem_w_en [MP];
  word         mem_w_addr [MP];
  word         mem_w_data [MP];
  logic [31:0] retired_cnt, stores_cnt;

  always #5 clk = ~clk;

  retire_commit_unit #(.RETIRE_W(RW), .MEM_PORTS(MP), .SB_DEPTH(SD)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_retire_rows  (rows),
    .o_retire_ready (retire_ready),
    .o_reg_w_en     (reg_w_en),
    .o_reg_w_addr   (reg_w_addr),
    .o_reg_w_data   (reg_w_data),
    .o_st_r_addr    (st_r_addr),
    .i_st_r_data    (st_data),
    .i_mem_ready    (mem_ready),
    .o_mem_w_en     (mem_w_en),
    .o_mem_w_addr   (mem_w_addr),
    .o_mem_w_data   (mem_w_data),
    .o_sb_empty     (sb_empty),
    .o_retired_cnt  (retired_cnt),
    .o_stores_cnt   (stores_cnt)
  );

  typedef struct packed {
    logic [RW-1:0] en;
    p_reg [RW-1:0] addr;
    word  [RW-1:0] data;
  } reg_exp_t;

  store_buffer_entry_struct sbq[$];
  reg_exp_t                 regq[$];
  logic [31:0]              retired_m = '0;
  logic [31:0]              stores_m = '0;
  logic                     ready_m = 1'b1;
  logic                     checking = 1'b0;
  int                       checks = 0;
  int                       failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare presented outputs against the model, then retire what memory takes
  always @(negedge clk) begin
    if (checking) begin
      int n_exp;
      reg_exp_t r;
      n_exp = (sbq.size() < MP) ? sbq.size() : MP;
      for (int k = 0; k < MP; k++) begin
        chk($sformatf("mem_w_en[%0d]", k), 64'(mem_w_en[k]), 64'(k < n_exp));
        if (k < n_exp) begin
          chk($sformatf("mem_w_addr[%0d]", k), 64'(mem_w_addr[k]), 64'(sbq[k].addr));
          chk($sformatf("mem_w_data[%0d]", k), 64'(mem_w_data[k]), 64'(sbq[k].data));
        end
      end
      ready_m = (SD - sbq.size()) >= RW;
      chk("retire_ready", 64'(retire_ready), 64'(ready_m));
      chk("sb_empty", 64'(sb_empty), 64'(sbq.size() == 0));
      chk("retired_cnt", 64'(retired_cnt), 64'(retired_m));
      chk("stores_cnt", 64'(stores_cnt), 64'(stores_m));
      if (regq.size() == 0) begin
        chk("reg_scoreboard_underflow", 64'(regq.size()), 64'(1));
      end else begin
        r = regq.pop_front();
        for (int i = 0; i < RW; i++) begin
          chk($sformatf("reg_w_en[%0d]", i), 64'(reg_w_en[i]), 64'(r.en[i]));
          if (r.en[i]) begin
            chk($sformatf("reg_w_addr[%0d]", i), 64'(reg_w_addr[i]), 64'(r.addr[i]));
            chk($sformatf("reg_w_data[%0d]", i), 64'(reg_w_data[i]), 64'(r.data[i]));
          end
        end
      end
      if (mem_ready && rst_n) begin
        for (int k = 0; k < n_exp; k++) void'(sbq.pop_front());
        stores_m += 32'(n_exp);
      end
    end
  end

  // Advance one clock and apply the model effect of the edge just taken
  task automatic tick();
    reg_exp_t r;
    @(posedge clk);
    #1;
    r = '0;
    if (!rst_n) begin
      sbq.delete();
      retired_m = '0;
      stores_m  = '0;
      checking  = 1'b1;
    end else if (ready_m) begin
      for (int i = 0; i < RW; i++) begin
        if (rows[i].valid) begin
          retired_m++;
          if (rows[i].mem_write) begin
            sbq.push_back('{addr: rows[i].data, data: st_data[i]});
          end else if (rows[i].reg_write) begin
            r.en[i]   = 1'b1;
            r.addr[i] = rows[i].p_reg_addr_dst;
            r.data[i] = rows[i].data;
          end
        end
      end
    end
    if (checking) regq.push_back(r);
  endtask

  function automatic rob_row_struct mk(input logic v, input logic rw, input logic mw,
                                       input p_reg a, input word d);
    rob_row_struct x;
    x.valid = v; x.reg_write = rw; x.mem_write = mw; x.p_reg_addr_dst = a; x.data = d;
    return x;
  endfunction

  task automatic drive(input rob_row_struct r0, input rob_row_struct r1,
                       input word d0, input word d1, input logic mr);
    rows[0] = r0; rows[1] = r1; st_data[0] = d0; st_data[1] = d1; mem_ready = mr;
    tick();
  endtask

  task automatic idle(input logic mr, input int n);
    for (int c = 0; c < n; c++) drive('0, '0, $urandom, $urandom, mr);
  endtask

  initial begin
    rows[0] = '0; rows[1] = '0; st_data[0] = '0; st_data[1] = '0;
    idle(1'b0, 2);
    rst_n = 1'b1;
    idle(1'b1, 1);

    drive(mk(1, 1, 0, 7'd5, 32'h1234), '0, 0, 0, 1'b1);
    idle(1'b1, 2);

    drive(mk(1, 0, 1, 7'd1, 32'h40), mk(1, 0, 1, 7'd2, 32'h44), 32'hAA, 32'hBB, 1'b1);
    idle(1'b1, 3);

    // Fill with memory stalled: fourth batch fits, fifth is held
    for (int b = 0; b < 5; b++)
      drive(mk(1, 0, 1, 7'd3, 32'h100 + 32'(b * 8)), mk(1, 0, 1, 7'd4, 32'h104 + 32'(b * 8)),
            32'hC00 + 32'(b), 32'hD00 + 32'(b), 1'b0);
    idle(1'b1, 6);

    drive(mk(0, 0, 1, 7'd9, 32'h70), mk(1, 0, 1, 7'd10, 32'h80), 32'h11, 32'h22, 1'b1);
    idle(1'b1, 2);

    drive(mk(1, 1, 1, 7'd12, 32'h90), '0, 32'h33, 0, 1'b1);
    idle(1'b1, 2);

    drive(mk(1, 0, 1, 7'd1, 32'hA0), mk(1, 0, 1, 7'd2, 32'hA4), 32'h1, 32'h2, 1'b0);
    drive(mk(1, 0, 1, 7'd1, 32'hA8), mk(1, 0, 1, 7'd2, 32'hAC), 32'h3, 32'h4, 1'b0);
    rst_n = 1'b0;
    idle(1'b1, 1);
    rst_n = 1'b1;
    idle(1'b1, 2);

    for (int c = 0; c < 400; c++) begin
      rob_row_struct r [RW];
      for (int i = 0; i < RW; i++)
        r[i] = mk($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 9) < 4,
                  p_reg'($urandom), $urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      drive(r[0], r[1], $urandom, $urandom, $urandom_range(0, 9) < 6);
    end
    rst_n = 1'b1;
    idle(1'b1, 8);
    chk("drained_sb_empty", 64'(sb_empty), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
